rr_arbiter16: RTL and testbench

RR_ARBITER16 -- requirements
Module: rr_arbiter16

---
 rtl/rr_arbiter16.sv | 81 ++++++++
 tb/tb_rr_arbiter16.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter16.sv
// rr_arbiter16: 16-way round-robin arbiter with registered one-hot grant held until done or request drop.
// Optional forced release after TIMEOUT_CYCLES busy cycles when RR_ARBITER16_TIMEOUT_EN is defined.
module rr_arbiter16 #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        gnt_valid,
  output logic        timeout
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES out of range 1..255");
  end
  logic [0:0]  r_state;
  logic [3:0]  r_last;
  logic [3:0]  r_idx;
  logic [15:0] r_gnt;
  logic [3:0]  w_pick;
  logic        w_found;
  logic        w_hit;
  logic        w_rel;
  // Search upward from last+1; k=16 wraps back onto last itself.
  always_comb begin
    w_pick  = '0;
    w_found = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      if (!w_found && req[r_last + 4'(k)]) begin
        w_pick  = r_last + 4'(k);
        w_found = 1'b1;
      end
    end
  end
  assign w_rel = done || !req[r_idx] || w_hit;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_last  <= 4'd15;
    end else if (r_state == IDLE) begin
      if (w_found) begin
        r_state <= BUSY;
        r_idx   <= w_pick;
        r_gnt   <= 16'h1 << w_pick;
      end
    end else if (w_rel) begin
      r_state <= IDLE;
      r_gnt   <= '0;
      r_idx   <= '0;
      r_last  <= r_idx;
    end
  end
`ifdef RR_ARBITER16_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic       r_timeout;
  assign w_hit = (r_state == BUSY) && (r_cnt == 8'(TIMEOUT_CYCLES - 1));
  // Pulse only when the limit alone caused the release.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_hit && !done && req[r_idx];
      r_cnt     <= (r_state == BUSY) ? r_cnt + 8'd1 : 8'd0;
    end
  end
  assign timeout = r_timeout;
`else
  assign w_hit   = 1'b0;
  assign timeout = 1'b0;
`endif
  assign gnt       = r_gnt;
  assign gnt_idx   = r_idx;
  assign gnt_valid = (r_state == BUSY);
endmodule

// File: tb/tb_rr_arbiter16.sv
// tb_rr_arbiter16: scoreboard bench for rr_arbiter16; expectations queued at drive time, popped after each edge.
module tb_rr_arbiter16;
`ifdef RR_ARBITER16_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        done = 1'b0;
  logic [15:0] req = '0;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_valid;
  logic        timeout;
  typedef struct packed {logic v; logic [3:0] idx; logic to;} exp_t;
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  rr_arbiter16 #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .gnt_valid(gnt_valid), .timeout(timeout)
  );
  always #5 clk = ~clk;
  function automatic exp_t mk(int i, logic to);
    exp_t e;
    e.v   = (i >= 0);
    e.idx = (i >= 0) ? 4'(i) : 4'd0;
    e.to  = to;
    return e;
  endfunction
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; done = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
  endtask
  task automatic test_reset();
    exp_t e;
    logic [15:0] eg;
    @(negedge clk);
    rst = 1'b1; req = 16'hFFFF; done = 1'b1;
    sb.push_back(mk(-1, 1'b0));
    @(posedge clk);
    #1;
    e = sb.pop_front();
    eg = e.v ? (16'h1 << e.idx) : 16'h0;
    checks++;
    if ({gnt_valid, gnt_idx, gnt, timeout} !== {e.v, e.idx, eg, e.to}) begin
      errors++;
      $display("FAIL reset: got v=%b idx=%0d gnt=%h to=%b, want v=%b idx=%0d gnt=%h to=%b",
               gnt_valid, gnt_idx, gnt, timeout, e.v, e.idx, eg, e.to);
    end
    rst = 1'b0; req = '0; done = 1'b0;
  endtask
  task automatic test_single();
    logic [15:0] rq[3] = '{16'h0001, 16'h0001, 16'h0000};
    logic        dn[3] = '{1'b0, 1'b1, 1'b0};
    int          ex[3] = '{0, -1, -1};
    exp_t e;
    logic [15:0] eg;
    apply_reset();
    for (int s = 0; s < 3; s++) begin
      @(negedge clk);
      req = rq[s]; done = dn[s];
      sb.push_back(mk(ex[s], 1'b0));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      eg = e.v ? (16'h1 << e.idx) : 16'h0;
      checks++;
      if ({gnt_valid, gnt_idx, gnt, timeout} !== {e.v, e.idx, eg, e.to}) begin
        errors++;
        $display("FAIL single step%0d: got v=%b idx=%0d gnt=%h to=%b, want v=%b idx=%0d gnt=%h to=%b",
                 s, gnt_valid, gnt_idx, gnt, timeout, e.v, e.idx, eg, e.to);
      end
    end
  endtask
  task automatic test_rotate();
    exp_t e;
    logic [15:0] eg;
    apply_reset();
    for (int s = 0; s < 34; s++) begin
      @(negedge clk);
      req = 16'hFFFF; done = s[0];
      sb.push_back(s[0] ? mk(-1, 1'b0) : mk((s / 2) % 16, 1'b0));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      eg = e.v ? (16'h1 << e.idx) : 16'h0;
      checks++;
      if ({gnt_valid, gnt_idx, gnt, timeout} !== {e.v, e.idx, eg, e.to}) begin
        errors++;
        $display("FAIL rotate step%0d: got v=%b idx=%0d gnt=%h to=%b, want v=%b idx=%0d gnt=%h to=%b",
                 s, gnt_valid, gnt_idx, gnt, timeout, e.v, e.idx, eg, e.to);
      end
    end
  endtask
  task automatic test_wrap();
    logic dn[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    int   ex[6] = '{0, -1, 15, -1, 0, -1};
    exp_t e;
    logic [15:0] eg;
    apply_reset();
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      req = 16'h8001; done = dn[s];
      sb.push_back(mk(ex[s], 1'b0));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      eg = e.v ? (16'h1 << e.idx) : 16'h0;
      checks++;
      if ({gnt_valid, gnt_idx, gnt, timeout} !== {e.v, e.idx, eg, e.to}) begin
        errors++;
        $display("FAIL wrap step%0d: got v=%b idx=%0d gnt=%h to=%b, want v=%b idx=%0d gnt=%h to=%b",
                 s, gnt_valid, gnt_idx, gnt, timeout, e.v, e.idx, eg, e.to);
      end
    end
  endtask
  task automatic test_req_drop();
    logic [15:0] rq[6] = '{16'h0020, 16'hFFF0, 16'hFFDF, 16'hFFFF, 16'hFFFF, 16'h0000};
    logic        dn[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    int          ex[6] = '{5, 5, -1, 6, -1, -1};
    exp_t e;
    logic [15:0] eg;
    apply_reset();
    for (int s = 0; s < 6; s++) begin
      @(negedge clk);
      req = rq[s]; done = dn[s];
      sb.push_back(mk(ex[s], 1'b0));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      eg = e.v ? (16'h1 << e.idx) : 16'h0;
      checks++;
      if ({gnt_valid, gnt_idx, gnt, timeout} !== {e.v, e.idx, eg, e.to}) begin
        errors++;
        $display("FAIL req_drop step%0d: got v=%b idx=%0d gnt=%h to=%b, want v=%b idx=%0d gnt=%h to=%b",
                 s, gnt_valid, gnt_idx, gnt, timeout, e.v, e.idx, eg, e.to);
      end
    end
  endtask
  task automatic test_mid_reset();
    logic [15:0] rq[9] = '{16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0200, 16'h0000, 16'h0000, 16'h0201, 16'h0201};
    logic        dn[9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    logic        rs[9] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    int          ex[9] = '{9, -1, 9, -1, 9, -1, -1, 0, -1};
    exp_t e;
    logic [15:0] eg;
    apply_reset();
    for (int s = 0; s < 9; s++) begin
      @(negedge clk);
      rst = rs[s]; req = rq[s]; done = dn[s];
      sb.push_back(mk(ex[s], 1'b0));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      eg = e.v ? (16'h1 << e.idx) : 16'h0;
      checks++;
      if ({gnt_valid, gnt_idx, gnt, timeout} !== {e.v, e.idx, eg, e.to}) begin
        errors++;
        $display("FAIL mid_reset step%0d: got v=%b idx=%0d gnt=%h to=%b, want v=%b idx=%0d gnt=%h to=%b",
                 s, gnt_valid, gnt_idx, gnt, timeout, e.v, e.idx, eg, e.to);
      end
    end
    rst = 1'b0;
  endtask
  task automatic test_timeout();
`ifdef RR_ARBITER16_TIMEOUT_EN
    logic dn[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int   ex[10] = '{0, 0, 0, 0, -1, 0, 0, 0, 0, -1};
    logic to[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`else
    logic dn[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int   ex[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, -1};
    logic to[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`endif
    exp_t e;
    logic [15:0] eg;
    apply_reset();
    for (int s = 0; s < 10; s++) begin
      @(negedge clk);
      req = 16'h0001; done = dn[s];
      sb.push_back(mk(ex[s], to[s]));
      @(posedge clk);
      #1;
      e = sb.pop_front();
      eg = e.v ? (16'h1 << e.idx) : 16'h0;
      checks++;
      if ({gnt_valid, gnt_idx, gnt, timeout} !== {e.v, e.idx, eg, e.to}) begin
        errors++;
        $display("FAIL timeout step%0d: got v=%b idx=%0d gnt=%h to=%b, want v=%b idx=%0d gnt=%h to=%b",
                 s, gnt_valid, gnt_idx, gnt, timeout, e.v, e.idx, eg, e.to);
      end
    end
  endtask
  initial begin
    test_reset();
    test_single();
    test_rotate();
    test_wrap();
    test_req_drop();
    test_mid_reset();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
